// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N byte requesters.
// Each transfer runs IDLE -> ISSUE -> WAIT_START -> WAIT_DONE, with a bounded wait for busy to rise.
module uart_tx_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int START_TO = 8,
    localparam int IW      = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_data,
    output logic [N-1:0]   o_gnt,
    output logic [W-1:0]   o_tx_data,
    output logic           o_tx_we,
    input  logic           i_tx_busy,
    output logic           o_busy,
    output logic [IW-1:0]  o_owner,
    output logic           o_timeout
);

    localparam int CW = $clog2(START_TO) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_owner;
    logic [W-1:0]    r_tx_data;
    logic [N-1:0]    r_gnt;
    logic            r_tx_we;
    logic            r_timeout;
    logic [CW-1:0]   r_cnt;

    logic            w_found;
    logic [IW-1:0]   w_winner;
    logic [IW-1:0]   w_idx;
    logic [W-1:0]    w_win_data;
    logic [CW-1:0]   w_cnt_next;

    // Scan from the requester after the last winner, wrapping mod N.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_found    = 1'b0;
        w_winner   = r_last;
        w_idx      = '0;
        w_win_data = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(r_last) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (IW'(k) == w_winner) begin
                w_win_data = i_data[k*W +: W];
            end
        end
    end

    assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_last    <= IW'(N - 1);
            r_owner   <= '0;
            r_tx_data <= '0;
            r_gnt     <= '0;
            r_tx_we   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            r_gnt     <= '0;
            r_tx_we   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !i_tx_busy) begin
                        r_tx_data <= w_win_data;
                        r_owner   <= w_winner;
                        r_last    <= w_winner;
                        r_gnt     <= {{(N-1){1'b0}}, 1'b1} << w_winner;
                        r_tx_we   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        // The byte is abandoned, not retried: its grant was already given.
                        if (w_cnt_next >= CW'(START_TO - 1)) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_tx_data = r_tx_data;
    assign o_tx_we   = r_tx_we;
    assign o_owner   = r_owner;
    assign o_timeout = r_timeout;
    assign o_busy    = (r_state != S_IDLE);

endmodule
